// File: rtl/xmm_write_back_unit.sv
// rtl/xmm_write_back_unit.sv - XMM write-back: source conversion to 64-bit Q format, stage-1 register, write queue
// Optional feature macro: XMM_WB_SAT_EN (saturate fp32 overflow, report it on xmm_write_sat).
module xmm_write_back_unit #(
   parameter int FRAC_BITS = 15,
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        src,
   input  logic [ADDR_W-1:0] rd,
   input  logic [31:0]       alu_res,
   input  logic [31:0]       mem_read_data,
   input  logic [63:0]       fpu_res,
   output logic              xmm_write_en,
   input  logic              xmm_write_ready,
   output logic [ADDR_W-1:0] xmm_write_addr,
   output logic [63:0]       xmm_write_data,
   output logic              xmm_write_sat,
   output logic              pending
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic signed [9:0] FB_S = 10'(FRAC_BITS);

   logic [31:0]       w_fp;
   logic [7:0]        w_fp_exp;
   logic [63:0]       w_fp_man;
   logic signed [9:0] w_sh;
   logic signed [9:0] w_rsh;
   logic [63:0]       w_mag;
   logic [63:0]       w_fp_data;
   logic [63:0]       w_conv_data;
   logic [CNT_W-1:0]  w_occ;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_write_en;

   logic              r_s1_valid;
   logic [ADDR_W-1:0] r_s1_addr;
   logic [63:0]       r_s1_data;
   logic [ADDR_W-1:0] r_q_addr [DEPTH];
   logic [63:0]       r_q_data [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;

`ifdef XMM_WB_SAT_EN
   logic w_fp_sat;
   logic w_conv_sat;
   logic r_s1_sat;
   logic r_q_sat [DEPTH];
`endif

   // fp32 -> Q: the mantissa is shifted by (exp - 150 + FRAC_BITS); negative shifts truncate toward zero
   always_comb begin
      w_fp      = src[2] ? mem_read_data : alu_res;
      w_fp_exp  = w_fp[30:23];
      w_fp_man  = {40'd0, 1'b1, w_fp[22:0]};
      w_sh      = $signed({2'b00, w_fp_exp}) + FB_S - 10'sd150;
      w_rsh     = -w_sh;
      w_mag     = '0;
      if (w_sh >= 10'sd0) begin
         if (w_sh < 10'sd64) w_mag = w_fp_man << w_sh[5:0];
      end else if (w_rsh < 10'sd24) begin
         w_mag = w_fp_man >> w_rsh[4:0];
      end
      w_fp_data = w_fp[31] ? (64'd0 - w_mag) : w_mag;
`ifdef XMM_WB_SAT_EN
      w_fp_sat = 1'b0;
      if (w_fp_exp == 8'hFF && w_fp[22:0] != 23'd0) begin
         w_fp_data = '0;
         w_fp_sat  = 1'b1;
      end else if (w_sh >= 10'sd40) begin
         // shift of 40 puts the hidden bit at 2^63; infinity also lands here
         w_fp_data = w_fp[31] ? {1'b1, 63'd0} : {1'b0, {63{1'b1}}};
         w_fp_sat  = 1'b1;
      end
`else
      if (w_fp_exp == 8'hFF) w_fp_data = '0;
`endif
      if (w_fp_exp == 8'd0) w_fp_data = '0;
   end

   always_comb begin
      w_conv_data = '0;
      case (src[2:1])
         2'b00:   w_conv_data = (src[0] ? {{32{alu_res[31]}}, alu_res} : {32'd0, alu_res}) << FRAC_BITS;
         2'b11:   w_conv_data = fpu_res;
         default: w_conv_data = w_fp_data;
      endcase
   end

`ifdef XMM_WB_SAT_EN
   assign w_conv_sat = (src[2:1] == 2'b01 || src[2:1] == 2'b10) && w_fp_sat;
`endif

   // stage-1 plus queue occupancy bounds the number of accepted requests, so pushes never find the queue full
   assign w_occ      = r_count + CNT_W'(r_s1_valid);
   assign in_ready   = reset_n & (w_occ < CNT_W'(DEPTH));
   assign w_accept   = in_valid & in_ready;
   assign w_push     = r_s1_valid;
   assign w_write_en = (r_count != '0);
   assign w_pop      = w_write_en & xmm_write_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_s1_valid <= 1'b0;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_s1_addr <= rd;
         r_s1_data <= w_conv_data;
      end
      if (w_push) begin
         r_q_addr[r_wptr] <= r_s1_addr;
         r_q_data[r_wptr] <= r_s1_data;
      end
   end

`ifdef XMM_WB_SAT_EN
   always_ff @(posedge clk) begin
      if (w_accept) r_s1_sat <= w_conv_sat;
      if (w_push)   r_q_sat[r_wptr] <= r_s1_sat;
   end
   assign xmm_write_sat = w_write_en & r_q_sat[r_rptr];
`else
   assign xmm_write_sat = 1'b0;
`endif

   // payload is forced to zero when no write is offered, so stale queue contents never show
   assign xmm_write_en   = w_write_en;
   assign xmm_write_addr = w_write_en ? r_q_addr[r_rptr] : '0;
   assign xmm_write_data = w_write_en ? r_q_data[r_rptr] : '0;
   assign pending        = r_s1_valid | w_write_en;

endmodule
